dco_clock_generator: RTL and testbench



---
 rtl/dco_clock_generator_if.sv | 28 ++
 rtl/dco_clock_generator.sv | 135 +++++++++++++
 tb/tb_dco_clock_generator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/dco_clock_generator_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dco_clock_generator_if : control/handshake bundle of the DCO     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface dco_clock_generator_if #(
  parameter int WIDTH = 16
);
  logic             enable_i;
  logic [WIDTH-1:0] half_period_i;
  logic [WIDTH-1:0] phase_step_i;
  logic             phase_step_valid_i;
  logic             phase_step_ready_o;
  logic             generated_o;
  logic             rise_o;
  logic             running_o;

  modport master (
    output enable_i, half_period_i, phase_step_i, phase_step_valid_i,
    input  phase_step_ready_o, generated_o, rise_o, running_o
  );

  modport slave (
    input  enable_i, half_period_i, phase_step_i, phase_step_valid_i,
    output phase_step_ready_o, generated_o, rise_o, running_o
  );
endinterface
`default_nettype wire

// File: rtl/dco_clock_generator.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dco_clock_generator : counter-based DCO with one-shot phase steps |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module dco_clock_generator #(
  parameter int WIDTH = 16
) (
  input  wire logic              fpga_clk_i,
  input  wire logic              reset_i,
  dco_clock_generator_if.slave   bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_step;
  logic             r_pending;
  logic             r_ready;
  logic             r_gen;
  logic             r_rise;
  logic             r_running;

  logic [WIDTH-1:0] w_half_clamped;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_adj;
  logic [WIDTH-1:0] w_len;
  logic             w_accept;

  assign w_half_clamped = (bus.half_period_i == '0) ? WIDTH'(1) : bus.half_period_i;
  // Rising boundaries use the freshly sampled period, falling ones keep the stored one
  assign w_base   = (r_state == S_HIGH) ? r_period : w_half_clamped;
  assign w_sum    = {2'b00, w_base} + {{2{r_step[WIDTH-1]}}, r_step};
  assign w_len    = r_pending ? w_adj : w_base;
  assign w_accept = bus.phase_step_valid_i && r_ready && (r_state != S_IDLE);

  always_comb begin
    w_adj = w_sum[WIDTH-1:0];
    if (w_sum[WIDTH+1] || (w_sum == '0)) begin
      w_adj = WIDTH'(1);
    end else if (w_sum[WIDTH]) begin
      w_adj = '1;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_period  <= '0;
      r_step    <= '0;
      r_pending <= 1'b0;
      r_ready   <= 1'b1;
      r_gen     <= 1'b0;
      r_rise    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (w_accept) begin
        r_step    <= bus.phase_step_i;
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
          r_ready   <= 1'b1;
          if (bus.enable_i) begin
            r_state   <= S_HIGH;
            r_period  <= w_half_clamped;
            r_cnt     <= w_half_clamped - WIDTH'(1);
            r_gen     <= 1'b1;
            r_rise    <= 1'b1;
            r_running <= 1'b1;
          end
        end
        S_HIGH: begin
          if (r_cnt == '0) begin
            r_state <= S_LOW;
            r_gen   <= 1'b0;
            r_cnt   <= w_len - WIDTH'(1);
            if (r_pending) begin
              r_pending <= 1'b0;
              r_ready   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - WIDTH'(1);
          end
        end
        S_LOW: begin
          if (r_cnt == '0) begin
            if (bus.enable_i) begin
              r_state  <= S_HIGH;
              r_period <= w_half_clamped;
              r_gen    <= 1'b1;
              r_rise   <= 1'b1;
              r_cnt    <= w_len - WIDTH'(1);
              if (r_pending) begin
                r_pending <= 1'b0;
                r_ready   <= 1'b1;
              end
            end else begin
              // Pending or just-offered steps die with the run
              r_state   <= S_IDLE;
              r_running <= 1'b0;
              r_pending <= 1'b0;
              r_ready   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - WIDTH'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gen     <= 1'b0;
          r_running <= 1'b0;
          r_pending <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.generated_o        = r_gen;
  assign bus.rise_o             = r_rise;
  assign bus.running_o          = r_running;
  assign bus.phase_step_ready_o = r_ready;
endmodule
`default_nettype wire

// File: tb/tb_dco_clock_generator.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | tb_dco_clock_generator : directed half-period / step checks      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_dco_clock_generator;
  localparam int WIDTH = 16;
  localparam int LIMIT = 1000;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   n;
  logic bad;

  dco_clock_generator_if #(.WIDTH(WIDTH)) u_if ();

  dco_clock_generator #(.WIDTH(WIDTH)) u_dut (
    .fpga_clk_i (clk),
    .reset_i    (rst),
    .bus        (u_if.slave)
  );

  initial clk = 1'b0;
  always #1.25 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Counts negedge samples while generated_o holds lvl; ends on the first sample of the next half
  task automatic measure(input logic lvl, output int cnt);
    cnt = 0;
    while (u_if.generated_o == lvl && u_if.running_o && cnt < LIMIT) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    u_if.enable_i           = 1'b0;
    u_if.half_period_i      = 16'd40;
    u_if.phase_step_i       = '0;
    u_if.phase_step_valid_i = 1'b0;

    #2;
    check("rst_gen",   u_if.generated_o, 0);
    check("rst_rise",  u_if.rise_o, 0);
    check("rst_run",   u_if.running_o, 0);
    check("rst_ready", u_if.phase_step_ready_o, 1);
    #3 rst = 1'b0;

    // Free run at H=40
    @(negedge clk);
    u_if.enable_i = 1'b1;
    @(negedge clk);
    check("start_gen",  u_if.generated_o, 1);
    check("start_rise", u_if.rise_o, 1);
    check("start_run",  u_if.running_o, 1);
    measure(1'b1, n); check("h40_high", n, 40);
    check("low_rise0", u_if.rise_o, 0);
    measure(1'b0, n); check("h40_low", n, 40);
    check("rise_again", u_if.rise_o, 1);

    // +4 step accepted mid-HIGH stretches the following LOW only
    repeat (10) @(negedge clk);
    u_if.phase_step_i = 16'd4;
    u_if.phase_step_valid_i = 1'b1;
    @(negedge clk);
    u_if.phase_step_valid_i = 1'b0;
    check("p4_ready_lo", u_if.phase_step_ready_o, 0);
    measure(1'b1, n); check("p4_cur_high", n, 29);
    check("p4_ready_hi", u_if.phase_step_ready_o, 1);
    measure(1'b0, n); check("p4_low44", n, 44);
    measure(1'b1, n); check("p4_high40", n, 40);

    // -100 step clamps next HIGH to 1; second offer while pending is refused
    u_if.phase_step_i = 16'(-100);
    u_if.phase_step_valid_i = 1'b1;
    @(negedge clk);
    check("m100_ready_lo", u_if.phase_step_ready_o, 0);
    u_if.phase_step_i = 16'd7;
    measure(1'b0, n); check("m100_cur_low", n, 39);
    u_if.phase_step_valid_i = 1'b0;
    check("m100_ready_hi", u_if.phase_step_ready_o, 1);
    measure(1'b1, n); check("m100_high1", n, 1);
    measure(1'b0, n); check("m100_low40", n, 40);
    measure(1'b1, n); check("m100_high40", n, 40);

    // Period change 40->20 mid-HIGH takes effect at the next rising edge
    measure(1'b0, n); check("pc_low40a", n, 40);
    repeat (5) @(negedge clk);
    u_if.half_period_i = 16'd20;
    measure(1'b1, n); check("pc_cur_high", n, 35);
    measure(1'b0, n); check("pc_low40b", n, 40);
    measure(1'b1, n); check("pc_high20", n, 20);
    measure(1'b0, n); check("pc_low20", n, 20);

    // Disable mid-HIGH: finish HIGH and full LOW, then idle
    repeat (3) @(negedge clk);
    u_if.enable_i = 1'b0;
    measure(1'b1, n); check("dis_high", n, 17);
    measure(1'b0, n); check("dis_low", n, 20);
    check("dis_gen", u_if.generated_o, 0);
    check("dis_run", u_if.running_o, 0);
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (u_if.rise_o || u_if.generated_o || u_if.running_o) bad = 1'b1;
    end
    check("idle_quiet", bad, 0);

    // Async reset mid-HIGH with a step pending
    u_if.half_period_i = 16'd40;
    u_if.enable_i = 1'b1;
    @(negedge clk);
    check("re_gen", u_if.generated_o, 1);
    repeat (5) @(negedge clk);
    u_if.phase_step_i = 16'd4;
    u_if.phase_step_valid_i = 1'b1;
    @(negedge clk);
    u_if.phase_step_valid_i = 1'b0;
    check("ar_ready_lo", u_if.phase_step_ready_o, 0);
    #0.3 rst = 1'b1;
    #0.2;
    check("ar_gen",   u_if.generated_o, 0);
    check("ar_ready", u_if.phase_step_ready_o, 1);
    check("ar_run",   u_if.running_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_restart", u_if.generated_o, 1);
    measure(1'b1, n); check("ar_high40", n, 40);
    measure(1'b0, n); check("ar_low40", n, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
